// File: rtl/sc_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds and
// an optional first-word-fall-through output. Define SC_FIFO_ERR_EN for sticky overflow/underflow flags.
module sc_fifo_prog #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  read,
   input  logic [ADDR_WIDTH:0]   af_level,
   input  logic [ADDR_WIDTH:0]   ae_level,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   cnt,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_cnt;
   logic                  w_wr_acc;
   logic                  w_rd_acc;

   assign empty        = (r_cnt == '0);
   assign full         = (r_cnt == DEPTH_CNT);
   assign almost_full  = (r_cnt >= af_level);
   assign almost_empty = (r_cnt <= ae_level);
   assign cnt          = r_cnt;

   // A write into a full FIFO is dropped even when a read frees a slot that same cycle.
   assign w_wr_acc = write & ~full  & ~clear;
   assign w_rd_acc = read  & ~empty & ~clear;

   // NOTE: storage has no reset; stale words are unreachable once cnt and the pointers are cleared.
   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= data_in;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_cnt <= r_cnt + (ADDR_WIDTH+1)'(1);
            2'b01:   r_cnt <= r_cnt - (ADDR_WIDTH+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Remembers the last word shown so data_out holds steady once the FIFO drains or is cleared.
         logic [DATA_WIDTH-1:0] r_last;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_last <= '0;
            else          r_last <= data_out;
         end
         assign data_out = empty ? r_last : r_mem[r_rd_ptr];
         assign valid    = ~empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_dout;
         logic                  r_valid;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_dout  <= '0;
               r_valid <= 1'b0;
            end else begin
               if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
               r_valid <= w_rd_acc;
            end
         end
         assign data_out = r_dout;
         assign valid    = r_valid;
      end
   endgenerate

`ifdef SC_FIFO_ERR_EN
   logic r_overflow;
   logic r_underflow;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (clear) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (write & full)  r_overflow  <= 1'b1;
         if (read  & empty) r_underflow <= 1'b1;
      end
   end
   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sc_fifo_prog.sv
// Scoreboard bench for sc_fifo_prog: a standard-mode and a FWFT instance (DEPTH=4)
// driven by identical stimulus and compared against a queue model.
module tb_sc_fifo_prog;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;

   logic          clk      = 1'b0;
   logic          reset_n  = 1'b0;
   logic          clear    = 1'b0;
   logic          write    = 1'b0;
   logic          read     = 1'b0;
   logic [DW-1:0] data_in  = '0;
   logic [AW:0]   af_level = 3'd3;
   logic [AW:0]   ae_level = 3'd1;

   logic [DW-1:0] s_data_out, f_data_out;
   logic          s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
   logic          f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [AW:0]   s_cnt, f_cnt;

   sc_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_std (
      .clk(clk), .reset_n(reset_n), .clear(clear), .write(write), .data_in(data_in),
      .read(read), .af_level(af_level), .ae_level(ae_level), .data_out(s_data_out),
      .valid(s_valid), .full(s_full), .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .cnt(s_cnt), .overflow(s_ovf), .underflow(s_udf));

   sc_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_fwft (
      .clk(clk), .reset_n(reset_n), .clear(clear), .write(write), .data_in(data_in),
      .read(read), .af_level(af_level), .ae_level(ae_level), .data_out(f_data_out),
      .valid(f_valid), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .cnt(f_cnt), .overflow(f_ovf), .underflow(f_udf));

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] sb[$];
   logic [DW-1:0] exp_out_s = '0;
   logic [DW-1:0] exp_out_f = '0;
   logic          exp_ovf   = 1'b0;
   logic          exp_udf   = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_status();
      int c;
      c = sb.size();
      if (c > 0) exp_out_f = sb[0];
      check("s_cnt",   32'(s_cnt),   32'(c));
      check("f_cnt",   32'(f_cnt),   32'(c));
      check("s_empty", 32'(s_empty), 32'(c == 0));
      check("f_empty", 32'(f_empty), 32'(c == 0));
      check("s_full",  32'(s_full),  32'(c == DEPTH));
      check("f_full",  32'(f_full),  32'(c == DEPTH));
      check("s_af",    32'(s_af),    32'(c >= int'(af_level)));
      check("s_ae",    32'(s_ae),    32'(c <= int'(ae_level)));
      check("f_af",    32'(f_af),    32'(c >= int'(af_level)));
      check("f_ae",    32'(f_ae),    32'(c <= int'(ae_level)));
      check("s_ovf",   32'(s_ovf),   32'(exp_ovf));
      check("s_udf",   32'(s_udf),   32'(exp_udf));
      check("f_ovf",   32'(f_ovf),   32'(exp_ovf));
      check("f_udf",   32'(f_udf),   32'(exp_udf));
      check("f_valid", 32'(f_valid), 32'(c != 0));
      check("f_data",  32'(f_data_out), 32'(exp_out_f));
   endtask

   // Drives one cycle of stimulus from a falling edge and checks just after the rising edge.
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic clr);
      int   c;
      logic acc_w, acc_r;
      c       = sb.size();
      write   = w;
      read    = r;
      data_in = d;
      clear   = clr;
      acc_w   = w && !clr && (c < DEPTH);
      acc_r   = r && !clr && (c > 0);
`ifdef SC_FIFO_ERR_EN
      if (clr) begin
         exp_ovf = 1'b0;
         exp_udf = 1'b0;
      end else begin
         if (w && c == DEPTH) exp_ovf = 1'b1;
         if (r && c == 0)     exp_udf = 1'b1;
      end
`endif
      @(posedge clk);
      #1;
      if (clr) sb.delete();
      else begin
         if (acc_r) exp_out_s = sb.pop_front();
         if (acc_w) sb.push_back(d);
      end
      check("s_valid", 32'(s_valid), 32'(acc_r));
      check("s_data",  32'(s_data_out), 32'(exp_out_s));
      check_status();
      @(negedge clk);
      write = 1'b0;
      read  = 1'b0;
      clear = 1'b0;
   endtask

   initial begin
      #1;
      check("rst_s_valid", 32'(s_valid), 32'd0);
      check("rst_s_data",  32'(s_data_out), 32'd0);
      check_status();
      @(negedge clk);
      reset_n = 1'b1;

      // Fill, overflow attempt, then drain in order.
      step(1, 0, 8'hA1, 0);
      step(1, 0, 8'hB2, 0);
      step(1, 0, 8'hC3, 0);
      step(1, 0, 8'hD4, 0);
      step(1, 0, 8'hE5, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0);

      // Single word through the FWFT path, then drain.
      step(1, 0, 8'h5A, 0);
      step(0, 1, 8'h00, 0);

      // Pointer wrap: three rounds of push 3 / pop 3.
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h10 * (k + 1) + i), 0);
         for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);
      end

      // Simultaneous read/write on empty and on full.
      step(1, 1, 8'h77, 0);
      step(1, 0, 8'h78, 0);
      step(1, 0, 8'h79, 0);
      step(1, 0, 8'h7A, 0);
      step(1, 1, 8'h7B, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);

      // Clear with a concurrent write, then underflow on empty.
      step(1, 0, 8'h31, 0);
      step(1, 0, 8'h32, 0);
      step(1, 0, 8'h33, 1);
      step(0, 1, 8'h00, 0);
      step(1, 0, 8'h34, 1);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 80; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 15) == 0));

      // Asynchronous reset mid-operation with three words stored.
      step(1, 0, 8'h01, 1);
      step(1, 0, 8'hC1, 0);
      step(1, 0, 8'hC2, 0);
      step(1, 0, 8'hC3, 0);
      #2;
      reset_n = 1'b0;
      #1;
      sb.delete();
      exp_out_s = '0;
      exp_out_f = '0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
      check("arst_s_data",  32'(s_data_out), 32'd0);
      check("arst_s_valid", 32'(s_valid), 32'd0);
      check_status();
      @(negedge clk);
      reset_n = 1'b1;
      step(1, 0, 8'h99, 0);
      step(0, 1, 8'h00, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
